// File: rtl/bk_pkg.sv
// Shared types and helpers for the nibble-serial Brent-Kung subtractor.
// Optional signed overflow flag: BK_SUB_SIGNED_OVF_EN.
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/bk_nibble_subtractor_if.sv
// Request/result bundle of the nibble-serial subtractor.
// Optional signed overflow flag: BK_SUB_SIGNED_OVF_EN.
interface bk_nibble_subtractor_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             eq;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, eq, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, eq, ovf
  );

endinterface

// File: rtl/bk4_sub_slice.sv
// 4-bit Brent-Kung prefix slice computing x - y - bin.
// Optional signed overflow flag: BK_SUB_SIGNED_OVF_EN.
module bk4_sub_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic       g10, p10;
  logic       g32, p32;
  logic       g20, p20;
  logic       g30, p30;

  // grey cells on x and ~y
  assign p = x ^ ~y;
  assign g = x & ~y;

  // first black level
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];

  // second black level plus the odd fill-in
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;

  // green cells fold in carry-in = ~bin
  assign c[0] = ~bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g10 | (p10 & c[0]);
  assign c[3] = g20 | (p20 & c[0]);
  assign c[4] = g30 | (p30 & c[0]);

  assign d    = p ^ c[3:0];
  assign bout = ~c[4];

endmodule

// File: rtl/bk_nibble_subtractor.sv
// Nibble-serial a - b through one shared 4-bit prefix slice.
// Optional signed overflow flag: BK_SUB_SIGNED_OVF_EN.
module bk_nibble_subtractor
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  bk_nibble_subtractor_if.slave bus
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int CNT_W = $clog2(NIB);
  localparam int MSB   = WIDTH - 1;

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] diff_r;
  logic             bor_r;
  logic             borrow_r;
  logic             eq_r;
  logic [3:0]       x_nib;
  logic [3:0]       y_nib;
  logic [3:0]       d_nib;
  logic             bout;
  logic             accept;
  logic             last;
  logic             busy;
  logic             done;

  assign last = (cnt == CNT_W'(NIB - 1));

  // select the current nibble and merge its result into the partial diff
  always_comb begin
    x_nib   = a_r[cnt*NIB_W +: NIB_W];
    y_nib   = b_r[cnt*NIB_W +: NIB_W];
    acc_nxt = acc;
    acc_nxt[cnt*NIB_W +: NIB_W] = d_nib;
  end

  bk4_sub_slice u_slice (
    .x    (x_nib),
    .y    (y_nib),
    .bin  (bor_r),
    .d    (d_nib),
    .bout (bout)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt    = state;
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          nxt    = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = bus.start;
        nxt    = bus.start ? RUN : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // operand latch, nibble iteration and result capture on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      bor_r    <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      eq_r     <= 1'b0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= bus.b;
      cnt   <= '0;
      bor_r <= 1'b0;
    end else if (busy) begin
      acc   <= acc_nxt;
      bor_r <= bout;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        cnt      <= '0;
        diff_r   <= acc_nxt;
        borrow_r <= bout;
        eq_r     <= (acc_nxt == '0);
      end
    end
  end

`ifdef BK_SUB_SIGNED_OVF_EN
  logic ovf_r;

  // signed overflow: operand signs differ and result sign left a's
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (busy && last) begin
      ovf_r <= (a_r[MSB] != b_r[MSB]) &&
               (acc_nxt[MSB] != a_r[MSB]);
    end
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;
  assign bus.eq     = eq_r;

endmodule
